// File: rtl/immediate_fetcher.sv
// Immediate fetcher: pops 0..MAX_BYTES bytes from an instruction-byte FIFO
// and assembles them into a little-endian immediate. The value is sign- or
// zero-extended, and the result is presented with a one-cycle complete pulse.
// Optional feature: define IMMEDIATE_FETCHER_STALL_COUNT_EN to add the
// stall_cycles output, which counts the cycles a fetch waited on an empty FIFO.
module immediate_fetcher #(
    parameter int MAX_BYTES = 4,
    parameter int CW        = $clog2(MAX_BYTES) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CW-1:0]          num_bytes,
    input  logic                   sign_extend,
    input  logic                   clear,
    output logic                   busy,
    output logic                   complete,
    output logic [8*MAX_BYTES-1:0] immediate,
    output logic                   fifo_rd_en,
    input  logic [7:0]             fifo_rd_data,
    input  logic                   fifo_empty
`ifdef IMMEDIATE_FETCHER_STALL_COUNT_EN
    ,
    output logic [7:0]             stall_cycles
`endif
);

    localparam int IW   = 8 * MAX_BYTES;
    localparam int IDXW = (IW > 1) ? $clog2(IW) : 1;

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    state_t          state_r, state_s;
    logic [3:0]      len_r, requested_r, received_r;  // 4 bits hold 0..8 without wrap
    logic [3:0]      start_len_s;
    logic [7:0]      req_len_s;
    logic            pending_r;                       // a byte was popped last cycle
    logic            sx_r;
    logic            done_s;
    logic [IW-1:0]   data_r, data_s;
    logic            busy_r, complete_r;
    logic [IW-1:0]   immediate_r;

    // Keep the low len bytes and fill every byte above them with the sign (or zero).
    function automatic logic [IW-1:0] extend_value(input logic [IW-1:0] raw,
                                                   input logic [3:0]    len,
                                                   input logic          sx);
        logic [IW-1:0] res;
        logic          sign_bit;
        res      = {IW{1'b0}};
        sign_bit = 1'b0;
        if (len != 4'd0) begin
            sign_bit = raw[IDXW'(8 * int'(len) - 1)];
        end else begin
            sign_bit = 1'b0;
        end
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(len)) begin
                res[8*i +: 8] = raw[8*i +: 8];
            end else begin
                res[8*i +: 8] = {8{sx & sign_bit}};
            end
        end
        return res;
    endfunction

    // Clamp the requested length to MAX_BYTES.
    always_comb begin
        req_len_s = 8'(num_bytes);
        if (req_len_s > 8'(MAX_BYTES)) begin
            start_len_s = 4'(MAX_BYTES);
        end else begin
            start_len_s = req_len_s[3:0];
        end
    end

    // Merge the byte returned by the FIFO this cycle into the assembly buffer.
    always_comb begin
        data_s = data_r;
        if (pending_r) begin
            data_s[IDXW'(8 * int'(received_r)) +: 8] = fifo_rd_data;
        end else begin
            data_s = data_r;
        end
    end

    // Next-state logic, FIFO pop request and completion detect.
    always_comb begin
        state_s    = state_r;
        done_s     = 1'b0;
        fifo_rd_en = (state_r == READ) && !fifo_empty && (requested_r < len_r) && !clear;
        case (state_r)
            IDLE: begin
                if (start && !clear) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (clear) begin
                    state_s = IDLE;
                end else if ((len_r == 4'd0) || (pending_r && ((received_r + 4'd1) == len_r))) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = READ;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters, assembly buffer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            len_r       <= 4'd0;
            requested_r <= 4'd0;
            received_r  <= 4'd0;
            pending_r   <= 1'b0;
            sx_r        <= 1'b0;
            data_r      <= {IW{1'b0}};
            busy_r      <= 1'b0;
            complete_r  <= 1'b0;
            immediate_r <= {IW{1'b0}};
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s == READ);
            complete_r <= done_s;
            if (done_s) begin
                immediate_r <= extend_value(data_s, len_r, sx_r);
            end else begin
                immediate_r <= immediate_r;
            end
            if (state_r == IDLE) begin
                pending_r <= 1'b0;
                if (start && !clear) begin
                    len_r       <= start_len_s;
                    sx_r        <= sign_extend;
                    requested_r <= 4'd0;
                    received_r  <= 4'd0;
                    data_r      <= {IW{1'b0}};
                end else begin
                    len_r <= len_r;
                end
            end else if (clear) begin
                // Abort: any byte in flight is dropped.
                pending_r   <= 1'b0;
                requested_r <= 4'd0;
                received_r  <= 4'd0;
            end else begin
                pending_r <= fifo_rd_en;
                data_r    <= data_s;
                if (fifo_rd_en) begin
                    requested_r <= requested_r + 4'd1;
                end else begin
                    requested_r <= requested_r;
                end
                if (pending_r) begin
                    received_r <= received_r + 4'd1;
                end else begin
                    received_r <= received_r;
                end
            end
        end
    end

    assign busy      = busy_r;
    assign complete  = complete_r;
    assign immediate = immediate_r;

`ifdef IMMEDIATE_FETCHER_STALL_COUNT_EN
    logic [7:0] stall_r;

    // Count cycles a fetch still needs bytes but the FIFO is empty; saturates at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_r <= 8'd0;
        end else if ((state_r == IDLE) && start && !clear) begin
            stall_r <= 8'd0;
        end else if ((state_r == READ) && fifo_empty && (requested_r < len_r) && (stall_r != 8'hFF)) begin
            stall_r <= stall_r + 8'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_cycles = stall_r;
`endif

endmodule

// File: tb/tb_immediate_fetcher.sv
// Scoreboard bench for immediate_fetcher: the driver pushes expected results,
// and a monitor pops them on every complete pulse.
module tb_immediate_fetcher;

    localparam int MAXB = 4;
    localparam int CWB  = $clog2(MAXB) + 1;
    localparam int IW   = 8 * MAXB;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [CWB-1:0]  num_bytes = '0;
    logic            sign_extend = 1'b0;
    logic            clear = 1'b0;
    logic            busy, complete, fifo_rd_en, fifo_empty;
    logic [IW-1:0]   immediate;
    logic [7:0]      fifo_rd_data;
`ifdef IMMEDIATE_FETCHER_STALL_COUNT_EN
    logic [7:0]      stall_cycles;
`endif

    immediate_fetcher dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_bytes    (num_bytes),
        .sign_extend  (sign_extend),
        .clear        (clear),
        .busy         (busy),
        .complete     (complete),
        .immediate    (immediate),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty)
`ifdef IMMEDIATE_FETCHER_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFO: byte array with write pointer owned by the driver.
    logic [7:0] mem [1024];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       force_empty = 1'b0;
    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr % 1024];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    typedef struct {
        logic [IW-1:0] val;
        int            cyc;
        int            reads;
    } exp_t;

    exp_t          exp_q[$];
    logic [7:0]    fb [8];
    logic [IW-1:0] last_val = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: little-endian sum of the bytes, then sign fill above byte L-1.
    function automatic logic [IW-1:0] model(input int L, input bit sx);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < L; i++) v = v | (64'(fb[i]) << (8 * i));
        if (sx && L > 0 && fb[L-1][7]) begin
            for (int i = L; i < 8; i++) v = v | (64'hFF << (8 * i));
        end
        return v[IW-1:0];
    endfunction

    task automatic fetch(input int n, input bit sx, input int nload, input int stall,
                         input int xreads, input bit expect_done, input bit hold, input bit rel);
        int   L;
        int   nl;
        exp_t e;
        L  = (n > MAXB) ? MAXB : n;
        nl = (nload < 0) ? L : nload;
        @(posedge clk); #1;
        for (int j = 0; j < nl; j++) begin
            mem[wr_ptr % 1024] = fb[j];
            wr_ptr++;
        end
        e.val   = model(L, sx);
        e.cyc   = (stall < 0) ? -1 : cyc + L + 2 + stall;
        e.reads = L + xreads;
        if (expect_done) begin
            exp_q.push_back(e);
            last_val = e.val;
        end
        if (rel) reset = 1'b1;
        start       = 1'b1;
        num_bytes   = CWB'(n);
        sign_extend = sx;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            if (rnd) force_empty = ($urandom_range(0, 2) == 0);
            n++;
        end
        force_empty = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL completion_timeout: got %0d pending fetches expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                int   rd_seen;
                int   rd_base;
                rd_seen = 0;
                rd_base = 0;
                forever begin
                    @(negedge clk);
                    if (fifo_rd_en) begin
                        rd_seen++;
                        chk("rd_en_while_empty", 64'(fifo_empty), 64'd0);
                    end
                    if (complete) begin
                        chk("busy_during_complete", 64'(busy), 64'd0);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_complete: got complete=1 expected no pulse at cycle %0d", cyc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("immediate", 64'(immediate), 64'(e.val));
                            if (e.cyc >= 0) chk("complete_cycle", 64'(cyc), 64'(e.cyc));
                            chk("read_count", 64'(rd_seen - rd_base), 64'(e.reads));
                            rd_base = rd_seen;
                        end
                    end
                end
            end
            begin : stimulus
                repeat (3) @(posedge clk);
                #1;
                chk("reset_busy", 64'(busy), 64'd0);
                chk("reset_complete", 64'(complete), 64'd0);
                chk("reset_immediate", 64'(immediate), 64'd0);
                chk("reset_rd_en", 64'(fifo_rd_en), 64'd0);

                // Two bytes 34 12, zero extend; start driven with reset release.
                fb[0] = 8'h34; fb[1] = 8'h12;
                fetch(2, 1'b0, -1, 0, 0, 1'b1, 1'b0, 1'b1);
                wait_done(1'b0);
                chk("two_byte_value", 64'(last_val), 64'h0000_1234);

                // Single byte 0x80 sign- then zero-extended.
                fb[0] = 8'h80;
                fetch(1, 1'b1, -1, 0, 0, 1'b1, 1'b0, 1'b0);
                wait_done(1'b0);
                fetch(1, 1'b0, -1, 0, 0, 1'b1, 1'b0, 1'b0);
                wait_done(1'b0);

                // Zero-length fetch with sign extension requested.
                fetch(0, 1'b1, -1, 0, 0, 1'b1, 1'b0, 1'b0);
                wait_done(1'b0);

                // Four bytes with a three-cycle empty stall after the first.
                fb[0] = 8'h78; fb[1] = 8'h56; fb[2] = 8'h34; fb[3] = 8'h12;
                fetch(4, 1'b0, -1, 3, 0, 1'b1, 1'b0, 1'b0);
                @(posedge clk); #1;
                force_empty = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                force_empty = 1'b0;
                wait_done(1'b0);
`ifdef IMMEDIATE_FETCHER_STALL_COUNT_EN
                chk("stall_cycles", 64'(stall_cycles), 64'd3);
`endif

                // Clear the cycle after the first byte is read.
                fb[0] = 8'h5A;
                fetch(4, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b0);
                @(posedge clk); #1;
                clear = 1'b1;
                @(posedge clk); #1;
                clear = 1'b0;
                chk("clear_busy", 64'(busy), 64'd0);
                chk("clear_immediate_held", 64'(immediate), 64'h1234_5678);
                fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC;
                fetch(3, 1'b1, -1, 0, 1, 1'b1, 1'b0, 1'b0);
                wait_done(1'b0);

                // Start held high across two one-byte fetches.
                fb[0] = 8'h11;
                fetch(1, 1'b0, -1, 0, 0, 1'b1, 1'b1, 1'b0);
                begin
                    exp_t e2;
                    mem[wr_ptr % 1024] = 8'h22;
                    wr_ptr++;
                    fb[0]    = 8'h22;
                    e2.val   = model(1, 1'b0);
                    e2.cyc   = cyc + 5;
                    e2.reads = 1;
                    exp_q.push_back(e2);
                    last_val = e2.val;
                end
                repeat (3) @(posedge clk);
                #1;
                start = 1'b0;
                wait_done(1'b0);

                // Reset in the middle of a four-byte fetch.
                fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
                fetch(4, 1'b0, -1, 0, 0, 1'b0, 1'b0, 1'b0);
                @(posedge clk);
                @(posedge clk);
                #3;
                reset = 1'b0;
                #1;
                chk("midreset_busy", 64'(busy), 64'd0);
                chk("midreset_complete", 64'(complete), 64'd0);
                chk("midreset_immediate", 64'(immediate), 64'd0);
                chk("midreset_rd_en", 64'(fifo_rd_en), 64'd0);
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b1;
                fb[0] = 8'hEF; fb[1] = 8'hBE;
                fetch(2, 1'b1, -1, 0, 2, 1'b1, 1'b0, 1'b0);
                wait_done(1'b0);

                // Random lengths (including over-length) and data; later half with stalls.
                for (int i = 0; i < 60; i++) begin
                    int n;
                    bit sx;
                    n  = $urandom_range(0, (1 << CWB) - 1);
                    sx = 1'($urandom_range(0, 1));
                    for (int j = 0; j < 8; j++) fb[j] = 8'($urandom);
                    fetch(n, sx, -1, (i < 30) ? 0 : -1, 0, 1'b1, 1'b0, 1'b0);
                    wait_done(i >= 30);
                end

                repeat (3) @(posedge clk);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join_any
    end

endmodule
